// File: rtl/alu_sequencer.sv
// Sequencing controller for the 8-bit ALU: one op at a time, fixed multi-cycle strobe schedule, C/Z/N flags.
// Optional decimal ADD (DSET state, alu_dec_en) is built in when ALU_SEQ_DEC_EN is defined.
module alu_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [2:0] op_code,
  input  logic       op_dest,
  input  logic       op_dec,
  input  logic       c_wr,
  input  logic       c_wr_val,
  input  logic       alu_cout,
  input  logic [7:0] res_in,
  output logic       alu_sums,
  output logic       alu_subs,
  output logic       alu_ands,
  output logic       alu_eors,
  output logic       alu_ors,
  output logic       alu_shftr,
  output logic       alu_shftcr,
  output logic       alu_dec_en,
  output logic       alu_reset,
  output logic       alu_adloa,
  output logic       alu_sboa,
  output logic       alu_cin,
  output logic       flag_c,
  output logic       flag_z,
  output logic       flag_n,
  output logic       done
);

`ifdef ALU_SEQ_DEC_EN
  localparam logic DEC_SUP = 1'b1;
`else
  localparam logic DEC_SUP = 1'b0;
`endif

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_LSR = 3'd5,
                         OP_ROR = 3'd6, OP_CLR = 3'd7;

  typedef enum logic [1:0] {IDLE, DSET, EXEC, OUT} state_t;

  state_t     state;
  logic [2:0] op_q;
  logic       dest_q, dec_q, dec_en_q;
  logic [6:0] strb;
  logic       dec_go;

  // Strobe bit order follows op_code; CLR has no strobe.
  function automatic logic [6:0] strobe_of(input logic [2:0] op);
    strobe_of = (op == OP_CLR) ? 7'd0 : (7'b1 << op);
  endfunction

  assign dec_go = DEC_SUP & op_dec & (op_code == OP_ADD);

  assign {alu_shftcr, alu_shftr, alu_ors, alu_eors, alu_ands, alu_subs, alu_sums} = strb;
  assign alu_dec_en = dec_en_q & DEC_SUP;
  assign alu_cin    = flag_c;

  // Outputs are registered decodes of the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      op_ready  <= 1'b1;
      strb      <= '0;
      dec_en_q  <= 1'b0;
      alu_reset <= 1'b1;
      alu_adloa <= 1'b0;
      alu_sboa  <= 1'b0;
      done      <= 1'b0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      op_q      <= OP_ADD;
      dest_q    <= 1'b0;
      dec_q     <= 1'b0;
    end else begin
      op_ready  <= 1'b0;
      strb      <= '0;
      dec_en_q  <= 1'b0;
      alu_reset <= 1'b0;
      alu_adloa <= 1'b0;
      alu_sboa  <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (c_wr) flag_c <= c_wr_val;
          if (op_valid) begin
            op_q   <= op_code;
            dest_q <= op_dest;
            dec_q  <= dec_go;
            if (dec_go) begin
              state    <= DSET;
              strb     <= 7'b0000001;
              dec_en_q <= 1'b1;
            end else begin
              state <= EXEC;
              strb  <= strobe_of(op_code);
              if (op_code == OP_CLR) begin
                alu_reset <= 1'b1;
                done      <= 1'b1;
              end
            end
          end else begin
            op_ready <= 1'b1;
          end
        end
        DSET: begin
          state    <= EXEC;
          strb     <= strobe_of(op_q);
          dec_en_q <= dec_q;
        end
        EXEC: begin
          if (op_q == OP_CLR) begin
            state    <= IDLE;
            op_ready <= 1'b1;
          end else begin
            state     <= OUT;
            alu_adloa <= ~dest_q;
            alu_sboa  <= dest_q;
            done      <= 1'b1;
            if (op_q == OP_ADD || op_q == OP_SUB || op_q == OP_LSR || op_q == OP_ROR)
              flag_c <= alu_cout;
          end
        end
        OUT: begin
          state    <= IDLE;
          op_ready <= 1'b1;
          flag_z   <= (res_in == 8'h00);
          flag_n   <= res_in[7];
        end
        default: begin
          state    <= IDLE;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
